sr_bank_sequencer: RTL and testbench
====================================

# sr_bank_sequencer

Sequencer and round-robin arbiter that shares a bank of WIDTH negative-edge SR flip-flops among NREQ requesters. Each granted request sets or clears one bit. The block drives a one-cycle S/R pulse, waits for the bank to settle, reads back the bit and acknowledges with a pass/fail flag. By construction it never presents S=R=1 to any bank bit. It sits between the requester logic and the SR bank, and is the only driver of the bank's S/R inputs.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of SR flip-flops in the bank
- IDXW, 3, width of a bit index; must satisfy 2^IDXW >= WIDTH
- REQW, 2, width of a requester number; must satisfy 2^REQW >= NREQ

Ports:
- Ck  in  1  clock; all state updates on the rising edge
- Rst  in  1  asynchronous, active-high reset
- Req  in  NREQ  Req[i] high: requester i has a pending operation; held until its Ack
- Op  in  NREQ  Op[i]: 1 = set the bit, 0 = clear the bit; stable while Req[i] is high
- Idx  in  NREQ*IDXW  slice [i*IDXW +: IDXW] is requester i's target bit
- Q  in  WIDTH  true outputs of the SR bank (read-back)
- S  out  WIDTH  set inputs to the bank, registered
- R  out  WIDTH  reset inputs to the bank, registered
- Ack  out  NREQ  one-cycle completion pulse to the owner
- Err  out  1  one-cycle pulse coincident with Ack; read-back mismatch or bad index
- Busy  out  1  high while an operation is in flight
- Owner  out  REQW  requester currently being served; 0 when idle

## Operation
- FSM states: IDLE, DRIVE, HOLD, CHECK, ACK. All outputs are registered.
- IDLE: if any Req bit is high, grant round-robin. Search starts at pointer Ptr, takes the first asserted Req at index >= Ptr, and wraps to 0. The winner's Op and Idx are latched into Owner/op_l/idx_l. Next state is DRIVE.
- IDLE with no Req: stay in IDLE.
- DRIVE: S[idx_l] = op_l and R[idx_l] = ~op_l. All other S/R bits are 0. Next state is HOLD.
- HOLD: S = R = 0. Next state is CHECK.
- CHECK: sample Q[idx_l]. Register Err = (Q[idx_l] != op_l). Set Ack[Owner] = 1 and Ptr = (Owner+1) mod NREQ. Next state is ACK.
- ACK: Ack and Err are visible for exactly this cycle. No arbitration happens here. Next state is IDLE, with Ack=0 and Err=0.
- Busy = 1 in DRIVE, HOLD, CHECK and ACK.
- Out-of-range index (idx_l >= WIDTH): DRIVE keeps S = R = 0, and CHECK forces Err = 1. The sequence is otherwise unchanged.
- Req withdrawn after grant: the operation still completes and Ack still pulses.
- The requester must drop Req[i] during its Ack cycle. A Req still high at the following IDLE edge is treated as a new request.
- Invariants:
  - (S & R) == 0 at all times.
  - popcount(S|R) <= 1.
  - Ack is one-hot or zero.
  - Err is never high without Ack.
- Reset (asynchronous, any state): state goes to IDLE. S, R, Ack, Err, Busy, Owner and Ptr all clear to 0 immediately. An aborted operation gets no Ack. Its requester keeps Req high and is re-arbitrated after Rst falls, starting from Ptr = 0.

## Timing
- Edge numbering: edge 0 is the rising edge that sees Req in IDLE.
- Edge 0: S/R pulse is driven for the cycle after edge 0. Busy and Owner are valid from that cycle.
- Bank sampling: the bank's falling edge inside the DRIVE cycle captures the pulse.
- Edge 3: Q read-back is sampled.
- Ack/Err: high in the cycle between edge 3 and edge 4.
- Edge 4: back in IDLE. The next grant can occur at edge 5.
- Throughput: one operation per 5 cycles.
- Latency: 4 cycles from the sampled Req to the Ack cycle.
- Rst deasserting: the first possible grant is the first rising edge with Rst low.

## Test plan
- Reset, then requester 2 asks Op=1, Idx=5:
  - S = 8'b0010_0000 for exactly one cycle; R = 0.
  - Ack = 4'b0100 four cycles later, with Err = 0.
  - Q[5] reads 1.
- All four Req high, each with a distinct Idx:
  - Grants come in order 0, 1, 2, 3, 5 cycles apart.
  - After the last Ack, re-requesting from 1 and 3 grants 1 first (Ptr wrapped to 0).
- Clear after set on the same bit (Op=0, Idx=5):
  - R = 8'b0010_0000 for one cycle; S = 0 the whole time.
  - Ack with Err = 0, and Q[5] = 0.
  - The monitor checks (S & R) == 0 every cycle.
- WIDTH=6 with Idx=7:
  - S = R = 0 throughout the operation.
  - Ack pulses with Err = 1.
  - The bank state is unchanged.
- Read-back mismatch, using a bank model stuck at Q[3] = 0 and Op=1, Idx=3:
  - Ack with Err = 1.
- Rst asserted mid-DRIVE:
  - S, R and Busy go to 0 immediately, and no Ack is issued.
  - With Req held, after Rst falls the same requester is granted and completes normally.

Source files
------------

// File: rtl/sr_bank_sequencer.sv
// sr_bank_sequencer: round-robin arbiter plus sequencer that shares one bank of
// negative-edge SR flip-flops among NREQ requesters. Each granted request drives a
// single-cycle S or R pulse on one bank bit, lets the bank settle, reads the bit back
// and acknowledges the owner with a pass/fail flag. S and R are never both high.
module sr_bank_sequencer #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3,
  parameter int unsigned REQW  = 2
) (
  input  logic                 Ck,
  input  logic                 Rst,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ-1:0]      Op,
  input  logic [NREQ*IDXW-1:0] Idx,
  input  logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     S,
  output logic [WIDTH-1:0]     R,
  output logic [NREQ-1:0]      Ack,
  output logic                 Err,
  output logic                 Busy,
  output logic [REQW-1:0]      Owner
);

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StHold,
    StCheck,
    StAck
  } state_e;

  state_e state_q, state_d;

  logic [REQW-1:0]  ptr_q, ptr_d;
  logic [REQW-1:0]  owner_q, owner_d;
  logic             op_q, op_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Arbitration results
  logic             grant_valid;
  logic [REQW-1:0]  grant_owner;
  logic             grant_op;
  logic [IDXW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_mask;

  // Read-back of the latched target bit
  logic [WIDTH-1:0] idx_mask;
  logic             idx_in_range;
  logic             q_bit;

  // One-hot decode of a bit index; an out-of-range index decodes to all zeros, which is
  // what keeps S = R = 0 for bad indices without any extra gating.
  function automatic logic [WIDTH-1:0] bit_mask(input logic [IDXW-1:0] idx);
    logic [WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (idx == IDXW'(i)) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

  // Round-robin search: lowest asserted Req at or above ptr_q wins, else lowest overall.
  // Iterating downwards lets the last hit (the lowest index) overwrite earlier ones.
  always_comb begin
    logic            hi_valid;
    logic [REQW-1:0] hi_owner;
    logic            hi_op;
    logic [IDXW-1:0] hi_idx;
    logic [REQW-1:0] lo_owner;
    logic            lo_op;
    logic [IDXW-1:0] lo_idx;
    hi_valid = 1'b0;
    hi_owner = '0;
    hi_op    = 1'b0;
    hi_idx   = '0;
    lo_owner = '0;
    lo_op    = 1'b0;
    lo_idx   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (Req[i]) begin
        lo_owner = REQW'(i);
        lo_op    = Op[i];
        lo_idx   = Idx[i*IDXW +: IDXW];
        if (REQW'(i) >= ptr_q) begin
          hi_valid = 1'b1;
          hi_owner = REQW'(i);
          hi_op    = Op[i];
          hi_idx   = Idx[i*IDXW +: IDXW];
        end
      end
    end
    grant_valid = |Req;
    grant_owner = hi_valid ? hi_owner : lo_owner;
    grant_op    = hi_valid ? hi_op    : lo_op;
    grant_idx   = hi_valid ? hi_idx   : lo_idx;
  end

  assign grant_mask   = bit_mask(grant_idx);
  assign idx_mask     = bit_mask(idx_q);
  assign idx_in_range = |idx_mask;
  assign q_bit        = |(Q & idx_mask);

  // Next-state and registered-output logic; S/R/Ack/Err default to zero so every pulse
  // lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    op_d    = op_q;
    idx_d   = idx_q;
    s_d     = '0;
    r_d     = '0;
    ack_d   = '0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d = StDrive;
          owner_d = grant_owner;
          op_d    = grant_op;
          idx_d   = grant_idx;
          busy_d  = 1'b1;
          // The pulse is registered here so it is on the bank pins during DRIVE.
          s_d     = grant_op ? grant_mask : '0;
          r_d     = grant_op ? '0 : grant_mask;
        end
      end
      StDrive: begin
        state_d = StHold;
      end
      StHold: begin
        state_d = StCheck;
      end
      StCheck: begin
        state_d = StAck;
        err_d   = ~idx_in_range | (q_bit != op_q);
        for (int i = 0; i < int'(NREQ); i++) begin
          ack_d[i] = (owner_q == REQW'(i));
        end
        ptr_d   = (owner_q == REQW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      end
      StAck: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        owner_d = '0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        owner_d = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation without an Ack.
  always_ff @(posedge Ck or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign S     = s_q;
  assign R     = r_q;
  assign Ack   = ack_q;
  assign Err   = err_q;
  assign Busy  = busy_q;
  assign Owner = owner_q;

endmodule

// File: tb/tb_sr_bank_sequencer.sv
// Bench for sr_bank_sequencer: an 8-bit and a 6-bit instance share one stimulus stream,
// each with its own negative-edge SR bank model; a transaction-level model predicts
// every output cycle by cycle and directed tests pin the model with literal values.
module tb_sr_bank_sequencer;
  localparam int NREQ = 4;
  localparam int IDXW = 3;
  localparam int REQW = 2;

  logic             Ck;
  logic             Rst;
  logic [NREQ-1:0]  Req;
  logic [NREQ-1:0]  Op;
  logic [NREQ*IDXW-1:0] Idx;

  logic [7:0] q8 = '0;
  logic [5:0] q6 = '0;
  logic [7:0] stuck0 = '0;
  logic [7:0] qv8;
  logic [7:0] S8, R8;
  logic [5:0] S6, R6;
  logic [NREQ-1:0] Ack8, Ack6;
  logic Err8, Err6, Busy8, Busy6;
  logic [REQW-1:0] Own8, Own6;

  int n_cmp = 0;
  int n_bad = 0;

  assign qv8 = q8 & ~stuck0;

  sr_bank_sequencer #(.NREQ(4), .WIDTH(8), .IDXW(3), .REQW(2)) dut8 (
    .Ck(Ck), .Rst(Rst), .Req(Req), .Op(Op), .Idx(Idx), .Q(qv8),
    .S(S8), .R(R8), .Ack(Ack8), .Err(Err8), .Busy(Busy8), .Owner(Own8)
  );

  sr_bank_sequencer #(.NREQ(4), .WIDTH(6), .IDXW(3), .REQW(2)) dut6 (
    .Ck(Ck), .Rst(Rst), .Req(Req), .Op(Op), .Idx(Idx), .Q(q6),
    .S(S6), .R(R6), .Ack(Ack6), .Err(Err6), .Busy(Busy6), .Owner(Own6)
  );

  initial begin
    Ck = 1'b0;
    forever #5 Ck = ~Ck;
  end

  // Negative-edge SR banks
  always @(negedge Ck) begin
    for (int i = 0; i < 8; i++) begin
      if (S8[i]) q8[i] <= 1'b1;
      else if (R8[i]) q8[i] <= 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      if (S6[i]) q6[i] <= 1'b1;
      else if (R6[i]) q6[i] <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an operation is a 4-cycle window (phase 0 = pulse, phase 2 =
  // read-back, phase 3 = ack) started by a round-robin pick when nothing is in flight.
  bit m_act;
  int m_ph, m_own, m_idx, m_ptr, m_c;
  bit m_op, m_err8, m_err6, m_found;

  always @(posedge Ck or posedge Rst) begin
    if (Rst) begin
      m_act = 0; m_ph = 0; m_own = 0; m_ptr = 0; m_idx = 0; m_op = 0;
      m_err8 = 0; m_err6 = 0;
    end else if (!m_act) begin
      if (Req != '0) begin
        m_found = 0;
        for (int k = 0; k < NREQ; k++) begin
          m_c = (m_ptr + k) % NREQ;
          if (!m_found && Req[m_c]) begin
            m_found = 1;
            m_own = m_c;
          end
        end
        m_op  = Op[m_own];
        m_idx = int'(Idx[m_own*IDXW +: IDXW]);
        m_act = 1;
        m_ph  = 0;
      end
    end else begin
      if (m_ph == 2) begin
        m_err8 = (m_idx >= 8) ? 1'b1 : (qv8[m_idx] != m_op);
        m_err6 = (m_idx >= 6) ? 1'b1 : (q6[m_idx] != m_op);
        m_ptr  = (m_own + 1) % NREQ;
      end
      m_ph++;
      if (m_ph == 4) m_act = 0;
    end
  end

  // Per-cycle comparison of both instances against the model, plus invariants
  logic [7:0] e_s8, e_r8;
  logic [5:0] e_s6, e_r6;
  logic [3:0] e_ack;
  always @(negedge Ck) begin
    e_s8 = '0; e_r8 = '0; e_s6 = '0; e_r6 = '0; e_ack = '0;
    if (m_act && m_ph == 0) begin
      if (m_idx < 8) begin
        if (m_op) e_s8[m_idx] = 1'b1; else e_r8[m_idx] = 1'b1;
      end
      if (m_idx < 6) begin
        if (m_op) e_s6[m_idx] = 1'b1; else e_r6[m_idx] = 1'b1;
      end
    end
    if (m_act && m_ph == 3) e_ack[m_own] = 1'b1;
    chk("S8", 32'(S8), 32'(e_s8));
    chk("R8", 32'(R8), 32'(e_r8));
    chk("S6", 32'(S6), 32'(e_s6));
    chk("R6", 32'(R6), 32'(e_r6));
    chk("Ack8", 32'(Ack8), 32'(e_ack));
    chk("Ack6", 32'(Ack6), 32'(e_ack));
    chk("Err8", 32'(Err8), 32'(m_act && m_ph == 3 && m_err8));
    chk("Err6", 32'(Err6), 32'(m_act && m_ph == 3 && m_err6));
    chk("Busy8", 32'(Busy8), 32'(m_act));
    chk("Busy6", 32'(Busy6), 32'(m_act));
    chk("Owner8", 32'(Own8), m_act ? 32'(m_own) : 32'd0);
    chk("Owner6", 32'(Own6), m_act ? 32'(m_own) : 32'd0);
    chk("inv_SandR8", 32'(S8 & R8), 32'd0);
    chk("inv_SandR6", 32'(S6 & R6), 32'd0);
    chk("inv_pop8", 32'($countones(S8 | R8) <= 1), 32'd1);
    chk("inv_ack_onehot8", 32'($onehot0(Ack8)), 32'd1);
    chk("inv_err_wo_ack8", 32'(Err8 && Ack8 == '0), 32'd0);
    chk("inv_err_wo_ack6", 32'(Err6 && Ack6 == '0), 32'd0);
  end

  // Requester behaviour: drop Req on Ack, record grants and what the bank pins saw
  int gown[$];
  int gcyc[$];
  int acks, rcyc8;
  logic [7:0] seen_s8, seen_r8;
  logic [5:0] seen_s6, seen_r6;
  logic lerr8, lerr6;

  task automatic run_ops(input int maxc);
    logic pb;
    pb = Busy8;
    gown.delete(); gcyc.delete();
    acks = 0; rcyc8 = 0; lerr8 = 0; lerr6 = 0;
    seen_s8 = '0; seen_r8 = '0; seen_s6 = '0; seen_r6 = '0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge Ck);
      if (Busy8 && !pb) begin
        gown.push_back(int'(Own8));
        gcyc.push_back(c);
      end
      pb = Busy8;
      seen_s8 |= S8; seen_r8 |= R8; seen_s6 |= S6; seen_r6 |= R6;
      if (R8 != '0) rcyc8++;
      if (Ack8 != '0) begin
        acks++;
        lerr8 = Err8;
        lerr6 = Err6;
        Req = Req & ~Ack8;
      end
      if (Req == '0 && !Busy8) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL run_timeout: actual=Req %b Busy %b required=idle within %0d cycles",
             Req, Busy8, maxc);
  endtask

  logic [5:0] q6_saved;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b1;
    Req = '0; Op = '0; Idx = '0;
    @(negedge Ck);
    @(negedge Ck);
    chk("rst_S", 32'(S8), 32'd0);
    chk("rst_Busy", 32'(Busy8), 32'd0);
    chk("rst_Ack", 32'(Ack8), 32'd0);
    chk("rst_Owner", 32'(Own8), 32'd0);

    // Test 1: requester 2 sets bit 5
    Rst = 1'b0;
    Req[2] = 1'b1; Op[2] = 1'b1; Idx[6 +: 3] = 3'd5;
    @(negedge Ck);
    chk("t1_S_pulse", 32'(S8), 32'h20);
    chk("t1_R_pulse", 32'(R8), 32'h0);
    chk("t1_Owner", 32'(Own8), 32'd2);
    @(negedge Ck);
    chk("t1_S_hold", 32'(S8), 32'h0);
    @(negedge Ck);
    @(negedge Ck);
    chk("t1_Ack", 32'(Ack8), 32'b0100);
    chk("t1_Err", 32'(Err8), 32'd0);
    Req = '0;
    @(negedge Ck);
    chk("t1_idle", 32'(Busy8), 32'd0);
    chk("t1_Q5", 32'(q8[5]), 32'd1);

    // Test 2: all four request after reset; then 1 and 3 re-request
    Rst = 1'b1;
    @(negedge Ck);
    Rst = 1'b0;
    Op = 4'b1111;
    Idx = {3'd4, 3'd3, 3'd2, 3'd1};
    Req = 4'b1111;
    run_ops(60);
    chk("t2_ngrants", 32'(gown.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", (gown.size() > i) ? 32'(gown[i]) : 32'hffff, 32'(i));
      if (i > 0) chk("t2_gap", (gcyc.size() > i) ? 32'(gcyc[i] - gcyc[i-1]) : 32'hffff, 32'd5);
    end
    chk("t2_acks", 32'(acks), 32'd4);
    Req = 4'b1010;
    run_ops(40);
    chk("t2_rr_first", (gown.size() > 0) ? 32'(gown[0]) : 32'hffff, 32'd1);
    chk("t2_rr_second", (gown.size() > 1) ? 32'(gown[1]) : 32'hffff, 32'd3);

    // Test 3: clear bit 5 via requester 1
    Op[1] = 1'b0; Idx[3 +: 3] = 3'd5;
    Req = 4'b0010;
    run_ops(20);
    chk("t3_S_never", 32'(seen_s8), 32'h0);
    chk("t3_R_seen", 32'(seen_r8), 32'h20);
    chk("t3_R_cycles", 32'(rcyc8), 32'd1);
    chk("t3_Err", 32'(lerr8), 32'd0);
    chk("t3_Q5", 32'(q8[5]), 32'd0);

    // Test 4: index 7 is out of range for the 6-bit instance
    q6_saved = q6;
    Op[0] = 1'b1; Idx[0 +: 3] = 3'd7;
    Req = 4'b0001;
    run_ops(20);
    chk("t4_S6_never", 32'(seen_s6), 32'h0);
    chk("t4_R6_never", 32'(seen_r6), 32'h0);
    chk("t4_Err6", 32'(lerr6), 32'd1);
    chk("t4_bank6", 32'(q6), 32'(q6_saved));
    chk("t4_Err8", 32'(lerr8), 32'd0);
    chk("t4_Q8_7", 32'(q8[7]), 32'd1);

    // Test 5: bank bit 3 stuck at 0 on the 8-bit instance
    stuck0 = 8'h08;
    Op[2] = 1'b1; Idx[6 +: 3] = 3'd3;
    Req = 4'b0100;
    run_ops(20);
    chk("t5_Err8", 32'(lerr8), 32'd1);
    chk("t5_Err6", 32'(lerr6), 32'd0);
    stuck0 = '0;

    // Test 6: reset during DRIVE, requester 3 holds Req and is re-served
    Op[3] = 1'b1; Idx[9 +: 3] = 3'd6;
    Req = 4'b1000;
    @(negedge Ck);
    chk("t6_S_drive", 32'(S8), 32'h40);
    #1 Rst = 1'b1;
    #1;
    chk("t6_S_rst", 32'(S8), 32'h0);
    chk("t6_R_rst", 32'(R8), 32'h0);
    chk("t6_Busy_rst", 32'(Busy8), 32'd0);
    @(negedge Ck);
    chk("t6_no_ack", 32'(Ack8), 32'd0);
    Rst = 1'b0;
    run_ops(20);
    chk("t6_regrant", (gown.size() > 0) ? 32'(gown[0]) : 32'hffff, 32'd3);
    chk("t6_acks", 32'(acks), 32'd1);
    chk("t6_Err8", 32'(lerr8), 32'd0);
    chk("t6_Err6", 32'(lerr6), 32'd1);
    chk("t6_Q6", 32'(q8[6]), 32'd1);

    @(negedge Ck);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
